alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequential front end that issues operations to the combinational ALU and collects its results; it is the producer of the ALU's G_sel/A/B inputs and the consumer of its G/ZCNVFlags outputs.
- Accepts RV32I-style ALU requests (funct3, bit-30 modifier, reg/imm operands) over a valid/ready handshake and decodes them to 4-bit G_sel.
- Drives registered operands to the ALU, captures result and flags, and returns them over a second valid/ready handshake.
- Sits between the instruction decode stage and the ALU.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHAMT_W, 5, shift-amount bits passed to the ALU for SLL/SRL/SRA.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_funct3  in  3  operation field
- req_f7b5  in  1  instruction bit 30 (SUB/SRA modifier)
- req_is_imm  in  1  1 = B operand from req_imm
- req_rs1  in  XLEN  A operand
- req_rs2  in  XLEN  B operand when req_is_imm=0
- req_imm  in  XLEN  sign-extended immediate
- alu_g_sel  out  4  opcode to ALU
- alu_a  out  XLEN  ALU A operand
- alu_b  out  XLEN  ALU B operand
- alu_g  in  XLEN  ALU result
- alu_flags  in  4  ALU ZCNV flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  XLEN  captured result
- rsp_flags  out  4  captured ZCNV flags
- rsp_illegal  out  1  request was illegal

Behaviour:
- G_sel encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- Decode by funct3:
  - 000: SUB if f7b5=1 and is_imm=0, else ADD.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRA if f7b5=1, else SRL.
  - 110: OR.
  - 111: AND.
- Illegal request: funct3=001 with f7b5=1.
- Operand B is req_imm when is_imm=1, otherwise req_rs2. For shift ops, B is zero-extended from its low SHAMT_W bits.
- FSM states are IDLE, ISSUE, CAPT, RESP. Transitions:
  - IDLE: req_ready=1. On req_valid, latch the decoded op and operands.
    - Legal request: go to ISSUE.
    - Illegal request: load result=0, flags=0, illegal=1 and go to RESP.
  - ISSUE: alu_g_sel/alu_a/alu_b are driven from registers; go to CAPT. The ALU settles during this cycle.
  - CAPT: alu_g_sel/alu_a/alu_b stay stable; register alu_g and alu_flags into rsp_result/rsp_flags, set illegal=0, go to RESP.
  - RESP: rsp_valid=1 and outputs held stable until rsp_ready=1; then go to IDLE.
- Latency and throughput:
  - Accept edge to rsp_valid high is 3 cycles for legal requests, 1 cycle for illegal requests.
  - Maximum throughput is one request per 4 cycles; there is no overlap.
- req_ready is high only in IDLE. A req_valid arriving in any other state is not accepted; the producer must hold it.
- alu_g_sel/alu_a/alu_b hold their last issued values outside ISSUE/CAPT and change only on a legal accept.
- rsp_ready asserted outside RESP has no effect. rsp_valid together with rsp_ready for one cycle completes exactly one transfer.
- Reset values (async, any state including mid-operation):
  - FSM returns to IDLE.
  - req_ready=1 once rst deasserts.
  - rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_illegal=0.
  - alu_g_sel=0000, alu_a=0, alu_b=0.
  - Any in-flight request is dropped with no response.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- With the macro defined:
  - Extra output perf_ops (32 bits) counts completed response transfers.
  - Extra output perf_illegal (32 bits) counts completed illegal responses.
  - Both counters wrap at 2^32, reset to 0 and increment on the rsp_valid and rsp_ready cycle.
- Without the macro: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - the G_sel localparams (ADD..AND);
  - the FSM state encoding (IDLE=0, ISSUE=1, CAPT=2, RESP=3);
  - the funct3 constants.
  - The ALU is refactored to import the G_sel constants from it.
- One sub-module, alu_op_decode (combinational), takes funct3/f7b5/is_imm/operands and produces g_sel, the muxed and masked B operand, and illegal.
- The FSM and registers stay in alu_issue_ctrl.

Test Plan:
- Bench uses a behavioural ALU model with standard RV32I semantics (SLT/SLTU true when A<B).
- Request funct3=000, f7b5=1, is_imm=0, rs1=10, rs2=3 -> alu_g_sel=0001 in ISSUE; rsp_valid 3 cycles after accept; rsp_result=7; rsp_illegal=0.
- Request funct3=101, f7b5=1, is_imm=1, rs1=0x80000000, imm=0x404 -> alu_b=4, alu_g_sel=1011, rsp_result=0xF8000000.
- Request funct3=001, f7b5=1 -> no change on alu_g_sel; rsp_valid the next cycle; rsp_result=0, rsp_flags=0, rsp_illegal=1.
- Hold rsp_ready=0 for 5 cycles in RESP while req_valid=1 -> rsp_* stable, req_ready=0, second request not accepted. rsp_ready=1 -> IDLE, then second request accepted.
- Assert rst during CAPT -> all outputs at reset values immediately; no response is ever produced for the dropped request.
- With ALU_ISSUE_PERF_EN: 3 legal and 2 illegal requests, all completed -> perf_ops=5, perf_illegal=2.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU G_sel opcodes, funct3 values and issue FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] c_G_ADD  = 4'b0000;
  localparam logic [3:0] c_G_SUB  = 4'b0001;
  localparam logic [3:0] c_G_SLL  = 4'b0010;
  localparam logic [3:0] c_G_SLT  = 4'b0100;
  localparam logic [3:0] c_G_SLTU = 4'b0110;
  localparam logic [3:0] c_G_XOR  = 4'b1000;
  localparam logic [3:0] c_G_SRL  = 4'b1010;
  localparam logic [3:0] c_G_SRA  = 4'b1011;
  localparam logic [3:0] c_G_OR   = 4'b1100;
  localparam logic [3:0] c_G_AND  = 4'b1110;

  localparam logic [2:0] c_F3_ADD  = 3'b000;
  localparam logic [2:0] c_F3_SLL  = 3'b001;
  localparam logic [2:0] c_F3_SLT  = 3'b010;
  localparam logic [2:0] c_F3_SLTU = 3'b011;
  localparam logic [2:0] c_F3_XOR  = 3'b100;
  localparam logic [2:0] c_F3_SR   = 3'b101;
  localparam logic [2:0] c_F3_OR   = 3'b110;
  localparam logic [2:0] c_F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : RV32I funct3/bit-30 decode to G_sel, B-operand select/mask.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [2:0]      i_funct3,
  input  logic            i_f7b5,
  input  logic            i_is_imm,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  output logic [3:0]      o_g_sel,
  output logic [XLEN-1:0] o_b,
  output logic            o_illegal
);

  logic [XLEN-1:0] w_src;
  logic            w_shift;

  assign w_src = i_is_imm ? i_imm : i_rs2;

  always_comb begin
    o_g_sel   = c_G_ADD;
    o_illegal = 1'b0;
    w_shift   = 1'b0;
    case (i_funct3)
      // Bit 30 selects SUB only for register-register; ADDI ignores it.
      c_F3_ADD:  o_g_sel = (i_f7b5 && !i_is_imm) ? c_G_SUB : c_G_ADD;
      c_F3_SLL: begin
        o_g_sel   = c_G_SLL;
        o_illegal = i_f7b5;
        w_shift   = 1'b1;
      end
      c_F3_SLT:  o_g_sel = c_G_SLT;
      c_F3_SLTU: o_g_sel = c_G_SLTU;
      c_F3_XOR:  o_g_sel = c_G_XOR;
      c_F3_SR: begin
        o_g_sel = i_f7b5 ? c_G_SRA : c_G_SRL;
        w_shift = 1'b1;
      end
      c_F3_OR:   o_g_sel = c_G_OR;
      default:   o_g_sel = c_G_AND;
    endcase
  end

  assign o_b = w_shift ? {{(XLEN-SHAMT_W){1'b0}}, w_src[SHAMT_W-1:0]} : w_src;

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Valid/ready front end that issues one op to the ALU and
//               returns its result; optional counters via ALU_ISSUE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_f7b5,
  input  logic            req_is_imm,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_imm,
  output logic [3:0]      alu_g_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_g,
  input  logic [3:0]      alu_flags,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic [3:0]      rsp_flags,
  output logic            rsp_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_illegal
`endif
);

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_capture;
  logic            w_done;
  logic [3:0]      w_dec_g_sel;
  logic [XLEN-1:0] w_dec_b;
  logic            w_dec_illegal;
  logic [3:0]      r_g_sel;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic [3:0]      r_flags;
  logic            r_illegal;

  alu_op_decode #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_decode (
    .i_funct3  (req_funct3),
    .i_f7b5    (req_f7b5),
    .i_is_imm  (req_is_imm),
    .i_rs2     (req_rs2),
    .i_imm     (req_imm),
    .o_g_sel   (w_dec_g_sel),
    .o_b       (w_dec_b),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          // Illegal requests never reach the ALU and answer immediately.
          w_next   = w_dec_illegal ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_CAPT;
      ST_CAPT: begin
        w_capture = 1'b1;
        w_next    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g_sel   <= c_G_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept && !w_dec_illegal) begin
        r_g_sel <= w_dec_g_sel;
        r_a     <= req_rs1;
        r_b     <= w_dec_b;
      end
      if (w_accept && w_dec_illegal) begin
        r_result  <= '0;
        r_flags   <= '0;
        r_illegal <= 1'b1;
      end
      if (w_capture) begin
        r_result  <= alu_g;
        r_flags   <= alu_flags;
        r_illegal <= 1'b0;
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign alu_g_sel   = r_g_sel;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign rsp_result  = r_result;
  assign rsp_flags   = r_flags;
  assign rsp_illegal = r_illegal;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_ops     <= '0;
      r_perf_illegal <= '0;
    end else if (w_done) begin
      r_perf_ops <= r_perf_ops + 32'd1;
      if (r_illegal) r_perf_illegal <= r_perf_illegal + 32'd1;
    end
  end

  assign perf_ops     = r_perf_ops;
  assign perf_illegal = r_perf_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Randomized self-checking bench for alu_issue_ctrl with a
//               behavioural ALU; perf counters checked with ALU_ISSUE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_f7b5;
  logic        req_is_imm;
  logic [31:0] req_rs1, req_rs2, req_imm;
  logic [3:0]  alu_g_sel;
  logic [31:0] alu_a, alu_b, alu_g;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops, perf_illegal;
`endif

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;
  int exp_ill = 0;
  logic [3:0]  last_gsel = 4'b0000;
  logic [31:0] last_a = '0, last_b = '0;
  logic [31:0] obs_result;
  logic [3:0]  obs_flags;
  logic        obs_illegal;
  logic [31:0] obs_b;
  logic [3:0]  obs_gsel;
  logic [2:0]  nxt_f3;
  logic        nxt_f7, nxt_ii;
  logic [31:0] nxt_rs1, nxt_rs2, nxt_imm;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_f7b5(req_f7b5), .req_is_imm(req_is_imm),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_g_sel(alu_g_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_g(alu_g), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_ops(perf_ops), .perf_illegal(perf_illegal)
`endif
  );

  // Behavioural ALU seen by the DUT.
  function automatic logic [31:0] alu_fn(input logic [3:0] g, input logic [31:0] a, input logic [31:0] b);
    case (g)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a << b[4:0];
      4'b0100: return {31'b0, ($signed(a) < $signed(b))};
      4'b0110: return {31'b0, (a < b)};
      4'b1000: return a ^ b;
      4'b1010: return a >> b[4:0];
      4'b1011: return 32'($signed(a) >>> b[4:0]);
      4'b1100: return a | b;
      4'b1110: return a & b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [3:0] flags_fn(input logic [3:0] g, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [32:0] s;
    logic c, v;
    r = alu_fn(g, a, b);
    c = 1'b0;
    v = 1'b0;
    if (g == 4'b0000) begin
      s = {1'b0, a} + {1'b0, b};
      c = s[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (g == 4'b0001) begin
      s = {1'b0, a} - {1'b0, b};
      c = ~s[32];
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end
    return {(r == 32'd0), c, r[31], v};
  endfunction

  always_comb begin
    alu_g     = alu_fn(alu_g_sel, alu_a, alu_b);
    alu_flags = flags_fn(alu_g_sel, alu_a, alu_b);
  end

  // Instruction-level expectations, straight from RV32I semantics.
  function automatic logic [3:0] exp_gsel(input logic [2:0] f3, input logic f7, input logic ii);
    case (f3)
      3'd0: return (f7 && !ii) ? 4'b0001 : 4'b0000;
      3'd1: return 4'b0010;
      3'd2: return 4'b0100;
      3'd3: return 4'b0110;
      3'd4: return 4'b1000;
      3'd5: return f7 ? 4'b1011 : 4'b1010;
      3'd6: return 4'b1100;
      default: return 4'b1110;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic f7, input logic ii,
                                             input logic [31:0] a, input logic [31:0] src);
    int unsigned sh;
    sh = src % 32;
    case (f3)
      3'd0: return (f7 && !ii) ? a - src : a + src;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(src)) ? 32'd1 : 32'd0;
      3'd3: return (a < src) ? 32'd1 : 32'd0;
      3'd4: return a ^ src;
      3'd5: return f7 ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | src;
      default: return a & src;
    endcase
  endfunction

  // Full request/response transaction; expects to start at a negedge in IDLE.
  task automatic run_txn(input logic [2:0] f3, input logic f7, input logic ii,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input int hold, input bit pre_next);
    logic illegal;
    logic [31:0] src, eb, er;
    logic [3:0] eg, ef, hold_gsel;
    int n;
    bit seen;
    illegal = (f3 == 3'd1) && f7;
    src = ii ? imm : rs2;
    eg  = exp_gsel(f3, f7, ii);
    eb  = (f3 == 3'd1 || f3 == 3'd5) ? (src % 32) : src;
    er  = illegal ? 32'd0 : ref_result(f3, f7, ii, rs1, src);
    ef  = illegal ? 4'd0 : flags_fn(eg, rs1, eb);
    hold_gsel = illegal ? last_gsel : eg;
    req_valid = 1'b1; req_funct3 = f3; req_f7b5 = f7; req_is_imm = ii;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle got %b want 1", req_ready);
    end
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n = 1; seen = 0;
    while (!seen && n <= 6) begin
      if (n <= 2) begin
        checks++;
        if (illegal ? ({alu_g_sel, alu_a, alu_b} !== {last_gsel, last_a, last_b})
                    : ({alu_g_sel, alu_a, alu_b} !== {eg, rs1, eb})) begin
          errors++;
          $display("FAIL alu_drive f3=%0d cyc%0d got gsel=%b a=%h b=%h want gsel=%b a=%h b=%h",
                   f3, n, alu_g_sel, alu_a, alu_b, hold_gsel, illegal ? last_a : rs1, illegal ? last_b : eb);
        end
      end
      if (rsp_valid === 1'b1) seen = 1;
      else begin
        // rsp_ready outside RESP must be ignored.
        rsp_ready = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
        n++;
      end
    end
    rsp_ready = 1'b0;
    checks++;
    if (!seen || n != (illegal ? 1 : 3)) begin
      errors++; $display("FAIL latency f3=%0d got %0d (seen=%0d) want %0d", f3, n, seen, illegal ? 1 : 3);
    end
    if (!seen) return;
    checks++;
    if ({rsp_result, rsp_flags, rsp_illegal} !== {er, ef, illegal}) begin
      errors++;
      $display("FAIL response f3=%0d f7=%b imm=%b got res=%h fl=%b ill=%b want res=%h fl=%b ill=%b",
               f3, f7, ii, rsp_result, rsp_flags, rsp_illegal, er, ef, illegal);
    end
    obs_result = rsp_result; obs_flags = rsp_flags; obs_illegal = rsp_illegal;
    obs_b = alu_b; obs_gsel = alu_g_sel;
    for (int i = 0; i < hold; i++) begin
      if (pre_next) begin
        req_valid = 1'b1; req_funct3 = nxt_f3; req_f7b5 = nxt_f7; req_is_imm = nxt_ii;
        req_rs1 = nxt_rs1; req_rs2 = nxt_rs2; req_imm = nxt_imm;
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_result, rsp_flags, rsp_illegal, alu_g_sel} !==
          {1'b1, 1'b0, er, ef, illegal, hold_gsel}) begin
        errors++;
        $display("FAIL resp_hold cyc%0d got v=%b rdy=%b res=%h gsel=%b want v=1 rdy=0 res=%h gsel=%b",
                 i, rsp_valid, req_ready, rsp_result, alu_g_sel, er, hold_gsel);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL resp_done got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
    end
    if (!illegal) begin
      last_gsel = eg; last_a = rs1; last_b = eb;
    end
    exp_ops++;
    if (illegal) exp_ill++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_illegal, rsp_flags, rsp_result, alu_g_sel, alu_a, alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b ill=%b fl=%b res=%h gsel=%b a=%h b=%h want all 0",
               rsp_valid, rsp_illegal, rsp_flags, rsp_result, alu_g_sel, alu_a, alu_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    run_txn(3'd0, 1'b1, 1'b0, 32'd10, 32'd3, 32'd0, 1, 1'b0);
    checks++;
    if ({obs_gsel, obs_result, obs_illegal} !== {4'b0001, 32'd7, 1'b0}) begin
      errors++; $display("FAIL sub_10_3 got gsel=%b res=%h ill=%b want 0001 7 0", obs_gsel, obs_result, obs_illegal);
    end
    run_txn(3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'h1234_5678, 32'h0000_0404, 0, 1'b0);
    checks++;
    if ({obs_gsel, obs_b, obs_result} !== {4'b1011, 32'd4, 32'hF800_0000}) begin
      errors++; $display("FAIL srai_4 got gsel=%b b=%h res=%h want 1011 4 f8000000", obs_gsel, obs_b, obs_result);
    end
  endtask

  task automatic test_illegal();
    run_txn(3'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd7, 32'd0, 2, 1'b0);
    checks++;
    if ({obs_gsel, obs_result, obs_flags, obs_illegal} !== {4'b1011, 32'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL illegal_sll got gsel=%b res=%h fl=%b ill=%b want 1011 0 0 1",
                         obs_gsel, obs_result, obs_flags, obs_illegal);
    end
  endtask

  task automatic test_back_to_back();
    nxt_f3 = 3'd4; nxt_f7 = 1'b0; nxt_ii = 1'b0;
    nxt_rs1 = 32'hA5A5_0F0F; nxt_rs2 = 32'h0F0F_FFFF; nxt_imm = 32'd0;
    run_txn(3'd6, 1'b0, 1'b1, 32'h0000_1000, 32'd0, 32'hFFFF_F800, 5, 1'b1);
    run_txn(nxt_f3, nxt_f7, nxt_ii, nxt_rs1, nxt_rs2, nxt_imm, 0, 1'b0);
    checks++;
    if (obs_result !== 32'hAAAA_F0F0) begin
      errors++; $display("FAIL second_req_xor got %h want aaaaf0f0", obs_result);
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [5];
    logic [31:0] v [3];
    logic [2:0] f3;
    corner[0] = 32'd0; corner[1] = 32'h8000_0000; corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'hFFFF_FFFF; corner[4] = 32'd1;
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < 3; k++)
        v[k] = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      f3 = 3'($urandom_range(0, 7));
      run_txn(f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v[0], v[1], v[2],
              int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_capt();
    req_valid = 1'b1; req_funct3 = 3'd0; req_f7b5 = 1'b0; req_is_imm = 1'b0;
    req_rs1 = 32'h1357_2468; req_rs2 = 32'h0000_0011; req_imm = 32'd0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_illegal, rsp_flags, rsp_result, alu_g_sel, alu_a, alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_mid_capt got v=%b res=%h gsel=%b a=%h b=%h want all 0",
               rsp_valid, rsp_result, alu_g_sel, alu_a, alu_b);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
        errors++; $display("FAIL dropped_req cyc%0d got valid=%b ready=%b want 0 1", i, rsp_valid, req_ready);
      end
    end
    last_gsel = 4'b0000; last_a = '0; last_b = '0;
    exp_ops = 0; exp_ill = 0;
  endtask

  task automatic test_perf();
`ifdef ALU_ISSUE_PERF_EN
    checks++;
    if ({perf_ops, perf_illegal} !== 64'd0) begin
      errors++; $display("FAIL perf_reset got ops=%0d ill=%0d want 0 0", perf_ops, perf_illegal);
    end
`endif
    run_txn(3'd0, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0, 0, 1'b0);
    run_txn(3'd1, 1'b1, 1'b1, 32'd5, 32'd6, 32'd1, 1, 1'b0);
    run_txn(3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 0, 1'b0);
    run_txn(3'd1, 1'b1, 1'b0, 32'd9, 32'd2, 32'd0, 0, 1'b0);
    run_txn(3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 2, 1'b0);
`ifdef ALU_ISSUE_PERF_EN
    checks++;
    if ({perf_ops, perf_illegal} !== {32'd5, 32'd2}) begin
      errors++; $display("FAIL perf_counts got ops=%0d ill=%0d want 5 2", perf_ops, perf_illegal);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_funct3 = '0; req_f7b5 = 1'b0; req_is_imm = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_capt();
    test_perf();
`ifdef ALU_ISSUE_PERF_EN
    test_random();
    checks++;
    if ({perf_ops, perf_illegal} !== {32'(exp_ops), 32'(exp_ill)}) begin
      errors++; $display("FAIL perf_scoreboard got ops=%0d ill=%0d want %0d %0d", perf_ops, perf_illegal, exp_ops, exp_ill);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
